// File: rtl/pmul_operand_seq.sv
// -----------------------------------------------------------------------------
// pmul_operand_seq
//
// Word-serial operand sequencer sitting between the point-multiply register
// block and the 256-bit scalar-multiply core (crypto clock domain).
//
// A start pulse fetches k, Gx and Gy as eight 32-bit words each, assembles
// them into 256-bit operand buses, starts the core, waits for completion
// (with a timeout) and writes the 256-bit Rx/Ry result back one word per
// cycle. The ready/busy/done/timeout status is exported to the register block.
//
// Ports
//   crypto_clk, reset_i          clock, synchronous active-high reset
//   I_start                      one-cycle start request (ignored unless idle)
//   O_ready / O_busy             idle / not idle
//   O_done                       one-cycle completion pulse (FIN state)
//   O_timeout                    sticky abort flag, cleared by the next start
//   k_addr, gx_addr, gy_addr     operand word index during LOAD
//   I_k_word                     k word, same-cycle read data
//   I_gx_word, I_gy_word         Gx/Gy words, one-cycle read latency
//   O_core_start                 one-cycle core start pulse
//   O_k, O_gx, O_gy              assembled operands, word i at [32i+31:32i]
//   I_core_done                  core completion (level or pulse)
//   I_core_rx, I_core_ry         core result
//   rx_addr, ry_addr             writeback word index
//   rx_wren, ry_wren             writeback strobes
//   O_rx_word, O_ry_word         writeback data
//
// State  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | waiting for I_start, O_ready high
// LOAD   | 9 cycles: addresses 0..7 then 7; k captured same cycle, Gx/Gy
//        | captured one cycle late
// RUN    | core started in first cycle; wait for done or timeout expiry
// WB     | 8 cycles: write captured Rx/Ry words 0..7
// FIN    | one cycle, O_done pulse
// -----------------------------------------------------------------------------
module pmul_operand_seq #(
    parameter int          pWORDS          = 8,
    parameter logic [23:0] pTIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic         crypto_clk,
    input  logic         reset_i,

    input  logic         I_start,
    output logic         O_ready,
    output logic         O_busy,
    output logic         O_done,
    output logic         O_timeout,

    output logic [2:0]   k_addr,
    output logic [2:0]   gx_addr,
    output logic [2:0]   gy_addr,
    input  logic [31:0]  I_k_word,
    input  logic [31:0]  I_gx_word,
    input  logic [31:0]  I_gy_word,

    output logic         O_core_start,
    output logic [255:0] O_k,
    output logic [255:0] O_gx,
    output logic [255:0] O_gy,
    input  logic         I_core_done,
    input  logic [255:0] I_core_rx,
    input  logic [255:0] I_core_ry,

    output logic [2:0]   rx_addr,
    output logic [2:0]   ry_addr,
    output logic         rx_wren,
    output logic         ry_wren,
    output logic [31:0]  O_rx_word,
    output logic [31:0]  O_ry_word
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        WB   = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [2:0]  LAST_IDX  = 3'(pWORDS - 1);
    // LOAD runs one cycle past the last address to absorb the Gx/Gy latency.
    localparam logic [3:0]  LOAD_LAST = 4'(pWORDS);
    // The timeout is a down-counter: loaded with N-1 and expiring at zero
    // gives exactly N RUN cycles.
    localparam logic [23:0] TMO_LOAD  = pTIMEOUT_CYCLES - 24'd1;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [23:0]    tmo_q, tmo_d;
    logic           timeout_q, timeout_d;
    logic [255:0]   k_q, k_d;
    logic [255:0]   gx_q, gx_d;
    logic [255:0]   gy_q, gy_d;
    logic [255:0]   rx_q, rx_d;
    logic [255:0]   ry_q, ry_d;

    logic [2:0]     ld_addr;
    logic [2:0]     cap_idx;

    // Address saturates at the last word during the extra LOAD cycle.
    assign ld_addr = idx_q[3] ? LAST_IDX : idx_q[2:0];
    // Gx/Gy data arriving now belongs to the previous cycle's address.
    assign cap_idx = idx_q[2:0] - 3'd1;

    assign O_k       = k_q;
    assign O_gx      = gx_q;
    assign O_gy      = gy_q;
    assign O_timeout = timeout_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        timeout_d    = timeout_q;
        k_d          = k_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        rx_d         = rx_q;
        ry_d         = ry_q;

        O_ready      = 1'b0;
        O_busy       = 1'b1;
        O_done       = 1'b0;
        O_core_start = 1'b0;
        k_addr       = 3'd0;
        gx_addr      = 3'd0;
        gy_addr      = 3'd0;
        rx_addr      = 3'd0;
        ry_addr      = 3'd0;
        rx_wren      = 1'b0;
        ry_wren      = 1'b0;
        O_rx_word    = 32'd0;
        O_ry_word    = 32'd0;

        case (state_q)
            IDLE: begin
                O_ready = 1'b1;
                O_busy  = 1'b0;
                if (I_start) begin
                    state_d   = LOAD;
                    idx_d     = 4'd0;
                    timeout_d = 1'b0;
                end
            end

            LOAD: begin
                k_addr  = ld_addr;
                gx_addr = ld_addr;
                gy_addr = ld_addr;
                if (!idx_q[3]) begin
                    k_d[{idx_q[2:0], 5'd0} +: 32] = I_k_word;
                end
                if (idx_q != 4'd0) begin
                    gx_d[{cap_idx, 5'd0} +: 32] = I_gx_word;
                    gy_d[{cap_idx, 5'd0} +: 32] = I_gy_word;
                end
                if (idx_q == LOAD_LAST) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    tmo_d   = TMO_LOAD;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            RUN: begin
                // The counter only holds its load value in the first RUN cycle.
                O_core_start = (tmo_q == TMO_LOAD);
                if (I_core_done) begin
                    // Done takes priority over a coincident expiry.
                    rx_d    = I_core_rx;
                    ry_d    = I_core_ry;
                    state_d = WB;
                    idx_d   = 4'd0;
                end else if (tmo_q == 24'd0) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    tmo_d = tmo_q - 24'd1;
                end
            end

            WB: begin
                rx_wren   = 1'b1;
                ry_wren   = 1'b1;
                rx_addr   = idx_q[2:0];
                ry_addr   = idx_q[2:0];
                O_rx_word = rx_q[{idx_q[2:0], 5'd0} +: 32];
                O_ry_word = ry_q[{idx_q[2:0], 5'd0} +: 32];
                if (idx_q[2:0] == LAST_IDX) begin
                    state_d = FIN;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            FIN: begin
                O_done  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            tmo_q     <= 24'd0;
            timeout_q <= 1'b0;
            k_q       <= 256'd0;
            gx_q      <= 256'd0;
            gy_q      <= 256'd0;
            rx_q      <= 256'd0;
            ry_q      <= 256'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            k_q       <= k_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
        end
    end

endmodule

// File: tb/tb_pmul_operand_seq.sv
// Directed bench for pmul_operand_seq. Instance A uses a 16-cycle timeout,
// instance B a 1-cycle timeout (done coinciding with expiry).
module tb_pmul_operand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start_a, done_a, start_b, done_b;
    logic [255:0] core_rx, core_ry;
    logic [31:0]  kmem [8];
    logic [31:0]  gxmem [8];
    logic [31:0]  gymem [8];

    logic         a_ready, a_busy, a_done, a_timeout, a_core_start, a_rx_wren, a_ry_wren;
    logic [2:0]   a_k_addr, a_gx_addr, a_gy_addr, a_rx_addr, a_ry_addr;
    logic [31:0]  a_k_word, a_gx_word, a_gy_word, a_rx_word, a_ry_word;
    logic [255:0] a_k, a_gx, a_gy;

    logic         b_ready, b_busy, b_done, b_timeout, b_core_start, b_rx_wren, b_ry_wren;
    logic [2:0]   b_k_addr, b_gx_addr, b_gy_addr, b_rx_addr, b_ry_addr;
    logic [31:0]  b_k_word, b_gx_word, b_gy_word, b_rx_word, b_ry_word;
    logic [255:0] b_k, b_gx, b_gy;

    // Register-block read model: k same cycle, Gx/Gy one cycle late.
    assign a_k_word = kmem[a_k_addr];
    assign b_k_word = kmem[b_k_addr];
    always @(posedge clk) begin
        a_gx_word <= gxmem[a_gx_addr];
        a_gy_word <= gymem[a_gy_addr];
        b_gx_word <= gxmem[b_gx_addr];
        b_gy_word <= gymem[b_gy_addr];
    end

    pmul_operand_seq #(.pWORDS(8), .pTIMEOUT_CYCLES(24'd16)) u_dut_a (
        .crypto_clk(clk), .reset_i(reset), .I_start(start_a),
        .O_ready(a_ready), .O_busy(a_busy), .O_done(a_done), .O_timeout(a_timeout),
        .k_addr(a_k_addr), .gx_addr(a_gx_addr), .gy_addr(a_gy_addr),
        .I_k_word(a_k_word), .I_gx_word(a_gx_word), .I_gy_word(a_gy_word),
        .O_core_start(a_core_start), .O_k(a_k), .O_gx(a_gx), .O_gy(a_gy),
        .I_core_done(done_a), .I_core_rx(core_rx), .I_core_ry(core_ry),
        .rx_addr(a_rx_addr), .ry_addr(a_ry_addr), .rx_wren(a_rx_wren), .ry_wren(a_ry_wren),
        .O_rx_word(a_rx_word), .O_ry_word(a_ry_word)
    );

    pmul_operand_seq #(.pWORDS(8), .pTIMEOUT_CYCLES(24'd1)) u_dut_b (
        .crypto_clk(clk), .reset_i(reset), .I_start(start_b),
        .O_ready(b_ready), .O_busy(b_busy), .O_done(b_done), .O_timeout(b_timeout),
        .k_addr(b_k_addr), .gx_addr(b_gx_addr), .gy_addr(b_gy_addr),
        .I_k_word(b_k_word), .I_gx_word(b_gx_word), .I_gy_word(b_gy_word),
        .O_core_start(b_core_start), .O_k(b_k), .O_gx(b_gx), .O_gy(b_gy),
        .I_core_done(done_b), .I_core_rx(core_rx), .I_core_ry(core_ry),
        .rx_addr(b_rx_addr), .ry_addr(b_ry_addr), .rx_wren(b_rx_wren), .ry_wren(b_ry_wren),
        .O_rx_word(b_rx_word), .O_ry_word(b_ry_word)
    );

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] rx;
        logic [31:0] ry;
    } wb_t;

    wb_t          wb_q [$];
    logic [255:0] exp_k_q [$];
    logic [255:0] exp_gx_q [$];
    logic [255:0] exp_gy_q [$];
    logic [255:0] last_k;
    int           checks = 0;
    int           failures = 0;

    task automatic check_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input int seed);
        for (int i = 0; i < 8; i++) begin
            kmem[i]  = 32'(i + 1) + 32'(seed) * 32'h0001_0000;
            gxmem[i] = 32'h100 + 32'(i) + 32'(seed) * 32'h0001_0000;
            gymem[i] = 32'h200 + 32'(i) + 32'(seed) * 32'h0001_0000;
            core_rx[32*i +: 32] = 32'hA000_0000 + 32'(i) + 32'(seed) * 32'h0001_0000;
            core_ry[32*i +: 32] = 32'hB000_0000 + 32'(i) + 32'(seed) * 32'h0001_0000;
        end
    endtask

    task automatic push_ops();
        logic [255:0] ek, egx, egy;
        for (int i = 0; i < 8; i++) begin
            ek[32*i +: 32]  = kmem[i];
            egx[32*i +: 32] = gxmem[i];
            egy[32*i +: 32] = gymem[i];
        end
        exp_k_q.push_back(ek);
        exp_gx_q.push_back(egx);
        exp_gy_q.push_back(egy);
        last_k = ek;
    endtask

    task automatic push_wb();
        wb_t e;
        for (int i = 0; i < 8; i++) begin
            e.addr = 3'(i);
            e.rx   = core_rx[32*i +: 32];
            e.ry   = core_ry[32*i +: 32];
            wb_q.push_back(e);
        end
    endtask

    task automatic check_ops(input logic [255:0] k, input logic [255:0] gx, input logic [255:0] gy);
        if (exp_k_q.size() == 0) begin
            check_v("ops_unexpected_core_start", k, 256'd0);
        end else begin
            check_v("op_k", k, exp_k_q.pop_front());
            check_v("op_gx", gx, exp_gx_q.pop_front());
            check_v("op_gy", gy, exp_gy_q.pop_front());
        end
    endtask

    task automatic check_wb(input logic rxw, input logic ryw, input logic [2:0] rxa,
                            input logic [2:0] rya, input logic [31:0] rxd, input logic [31:0] ryd);
        wb_t e;
        if (wb_q.size() == 0) begin
            check_i("wb_unexpected_write", 32'({rxw, ryw}), 32'd0);
        end else begin
            e = wb_q.pop_front();
            check_i("wb_wren_pair", 32'({rxw, ryw}), 32'd3);
            check_i("wb_rx_addr", 32'(rxa), 32'(e.addr));
            check_i("wb_ry_addr", 32'(rya), 32'(e.addr));
            check_i("wb_rx_word", rxd, e.rx);
            check_i("wb_ry_word", ryd, e.ry);
        end
    endtask

    // One transaction on instance A; returns to the caller at a negedge.
    task automatic txn_a(input int done_at, input bit hold_done, input bit poke_start,
                         input bit expect_wb, output int busy_n, output int wr_n,
                         output int done_n, output int cs_n, output int cs_at);
        int run_idx;
        int idle_n;
        bit prev_wr;
        bit pushed;
        int ld;
        run_idx = -1; idle_n = 0; prev_wr = 1'b0; pushed = 1'b0;
        busy_n = 0; wr_n = 0; done_n = 0; cs_n = 0; cs_at = -1;
        push_ops();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_i("timeout_cleared_on_start", 32'(a_timeout), 32'd0);
        for (int cyc = 0; cyc < 300 && idle_n < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (a_busy) busy_n++; else idle_n++;
            if (cyc <= 8) begin
                ld = (cyc > 7) ? 7 : cyc;
                check_i("load_addr", 32'({a_k_addr, a_gx_addr, a_gy_addr}), 32'({3{3'(ld)}}));
            end
            if (a_core_start) begin
                cs_n++;
                if (cs_at < 0) cs_at = cyc;
                if (run_idx < 0) run_idx = 0;
                check_ops(a_k, a_gx, a_gy);
            end
            if (a_rx_wren || a_ry_wren) begin
                wr_n++;
                check_wb(a_rx_wren, a_ry_wren, a_rx_addr, a_ry_addr, a_rx_word, a_ry_word);
            end
            if (a_done) begin
                done_n++;
                check_i("done_after_last_write", 32'(prev_wr), 32'(expect_wb));
            end
            prev_wr = a_rx_wren;
            if (run_idx >= 0 && !pushed && run_idx == done_at) begin
                done_a = 1'b1;
                push_wb();
                pushed = 1'b1;
            end else if (!hold_done) begin
                done_a = 1'b0;
            end
            if (run_idx >= 0) run_idx++;
            if (poke_start) start_a = (cyc == 3 || cyc == 11 || cyc == 18);
        end
        done_a  = 1'b0;
        start_a = 1'b0;
        check_i("txn_a_returned_idle", 32'(idle_n), 32'd5);
    endtask

    task automatic txn_b(input bit give_done, output int busy_n, output int wr_n, output int done_n);
        int idle_n;
        bit pushed;
        idle_n = 0; pushed = 1'b0; busy_n = 0; wr_n = 0; done_n = 0;
        push_ops();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int cyc = 0; cyc < 100 && idle_n < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (b_busy) busy_n++; else idle_n++;
            if (b_core_start) check_ops(b_k, b_gx, b_gy);
            if (b_rx_wren || b_ry_wren) begin
                wr_n++;
                check_wb(b_rx_wren, b_ry_wren, b_rx_addr, b_ry_addr, b_rx_word, b_ry_word);
            end
            if (b_done) done_n++;
            done_b = 1'b0;
            if (b_core_start && give_done && !pushed) begin
                done_b = 1'b1;
                push_wb();
                pushed = 1'b1;
            end
        end
        done_b = 1'b0;
        check_i("txn_b_returned_idle", 32'(idle_n), 32'd4);
    endtask

    initial begin
        int busy_n, wr_n, dn_n, cs_n, cs_at;
        bit hit;
        reset = 1'b1;
        start_a = 1'b0; done_a = 1'b0; start_b = 1'b0; done_b = 1'b0;
        set_mem(0);
        repeat (3) @(negedge clk);

        // Reset values
        check_i("rst_ready", 32'(a_ready), 32'd1);
        check_i("rst_busy", 32'(a_busy), 32'd0);
        check_i("rst_done", 32'(a_done), 32'd0);
        check_i("rst_timeout", 32'(a_timeout), 32'd0);
        check_i("rst_core_start", 32'(a_core_start), 32'd0);
        check_i("rst_wren", 32'({a_rx_wren, a_ry_wren}), 32'd0);
        check_i("rst_addrs", 32'({a_k_addr, a_gx_addr, a_gy_addr, a_rx_addr, a_ry_addr}), 32'd0);
        check_i("rst_rx_word", a_rx_word, 32'd0);
        check_i("rst_ry_word", a_ry_word, 32'd0);
        check_v("rst_k", a_k, 256'd0);
        check_v("rst_gx", a_gx, 256'd0);
        check_v("rst_gy", a_gy, 256'd0);
        check_i("rst_b_ready", 32'(b_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Normal transaction, done 5 cycles after start
        set_mem(0);
        txn_a(5, 1'b0, 1'b0, 1'b1, busy_n, wr_n, dn_n, cs_n, cs_at);
        check_i("t1_busy_cycles", busy_n, 32'd24);
        check_i("t1_writes", wr_n, 32'd8);
        check_i("t1_done_pulses", dn_n, 32'd1);
        check_i("t1_core_starts", cs_n, 32'd1);
        check_i("t1_core_start_cycle", cs_at, 32'd9);
        check_i("t1_timeout", 32'(a_timeout), 32'd0);
        check_i("t1_wb_drained", wb_q.size(), 32'd0);
        check_v("t1_k_held", a_k, last_k);

        // Timeout: core never completes
        set_mem(1);
        txn_a(-1, 1'b0, 1'b0, 1'b0, busy_n, wr_n, dn_n, cs_n, cs_at);
        check_i("t2_busy_cycles", busy_n, 32'd26);
        check_i("t2_writes", wr_n, 32'd0);
        check_i("t2_done_pulses", dn_n, 32'd1);
        check_i("t2_core_starts", cs_n, 32'd1);
        check_i("t2_timeout_set", 32'(a_timeout), 32'd1);
        check_v("t2_k_held", a_k, last_k);

        // Start pulses in LOAD/RUN/WB ignored, done held high through WB
        set_mem(2);
        txn_a(5, 1'b1, 1'b1, 1'b1, busy_n, wr_n, dn_n, cs_n, cs_at);
        check_i("t3_busy_cycles", busy_n, 32'd24);
        check_i("t3_writes", wr_n, 32'd8);
        check_i("t3_done_pulses", dn_n, 32'd1);
        check_i("t3_core_starts", cs_n, 32'd1);
        check_i("t3_timeout", 32'(a_timeout), 32'd0);

        // Done in the first RUN cycle
        set_mem(4);
        txn_a(0, 1'b0, 1'b0, 1'b1, busy_n, wr_n, dn_n, cs_n, cs_at);
        check_i("t4_busy_cycles", busy_n, 32'd19);
        check_i("t4_writes", wr_n, 32'd8);
        check_i("t4_done_pulses", dn_n, 32'd1);
        check_i("t4_timeout", 32'(a_timeout), 32'd0);

        // Reset asserted during WB cycle 3
        set_mem(3);
        hit = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            done_a = a_core_start;
            if (a_rx_wren && a_rx_addr == 3'd3) begin
                reset = 1'b1;
                hit = 1'b1;
            end
        end
        done_a = 1'b0;
        exp_k_q.delete(); exp_gx_q.delete(); exp_gy_q.delete(); wb_q.delete();
        check_i("t5_reached_wb3", 32'(hit), 32'd1);
        @(negedge clk);
        check_i("t5_wren_low", 32'({a_rx_wren, a_ry_wren}), 32'd0);
        check_i("t5_ready", 32'(a_ready), 32'd1);
        check_i("t5_busy", 32'(a_busy), 32'd0);
        check_i("t5_done", 32'(a_done), 32'd0);
        reset = 1'b0;
        dn_n = 0; wr_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_done) dn_n++;
            if (a_rx_wren || a_ry_wren) wr_n++;
        end
        check_i("t5_no_done", dn_n, 32'd0);
        check_i("t5_no_writes", wr_n, 32'd0);

        // Instance B: done coincides with 1-cycle timeout expiry
        set_mem(5);
        txn_b(1'b1, busy_n, wr_n, dn_n);
        check_i("t6_busy_cycles", busy_n, 32'd19);
        check_i("t6_writes", wr_n, 32'd8);
        check_i("t6_done_pulses", dn_n, 32'd1);
        check_i("t6_timeout", 32'(b_timeout), 32'd0);
        check_i("t6_wb_drained", wb_q.size(), 32'd0);

        // Instance B: 1-cycle timeout expiry with no done
        set_mem(6);
        txn_b(1'b0, busy_n, wr_n, dn_n);
        check_i("t7_busy_cycles", busy_n, 32'd11);
        check_i("t7_writes", wr_n, 32'd0);
        check_i("t7_done_pulses", dn_n, 32'd1);
        check_i("t7_timeout", 32'(b_timeout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
